// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state type and encodings.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    // Raw encodings for benches that probe state without the enum type.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference and borrow out of a single bit position.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - b_in, LSB first, one bit
// per clock through a single full_subtractor_cell and a borrow flop.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic             bw;
    logic [CNT_W-1:0] cnt;
    logic             cell_d, cell_bout;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

    full_subtractor_cell u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bw),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Final bit is being processed on this edge.
    assign last_bit = (state_q == SHIFT) && (cnt == CNT_W'(WIDTH - 1));
    assign res_next = {cell_d, res_sr[WIDTH-1:1]};

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, serial datapath and result load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            bw     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        bw   <= b_in;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    res_sr <= res_next;
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    bw     <= cell_bout;
                    cnt    <= cnt + CNT_W'(1);
                    // Results only become visible once the whole word is done.
                    if (last_bit) begin
                        diff   <= res_next;
                        borrow <= cell_bout;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Signed overflow; on the last edge the shift registers' LSBs hold the
    // operand MSBs, so no separate MSB capture is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (last_bit) begin
            ovf <= (a_sr[0] != b_sr[0]) && (cell_d != a_sr[0]);
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random bench for serial_subtractor (WIDTH=8) plus an exhaustive
// check of full_subtractor_cell. Overflow checks compile in with SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       b_in;
    logic       busy, done, borrow;
    logic [7:0] diff;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    logic       ca, cb, cbin, cd, cbout;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] prev_diff;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .b_in   (b_in),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    full_subtractor_cell u_cell (
        .a    (ca),
        .b    (cb),
        .bin  (cbin),
        .d    (cd),
        .bout (cbout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one operation; optionally re-pulse start (with a=b=1) after pulse_at
    // SHIFT edges. Returns edges from the start edge to done, and done count.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic binv,
                          input int pulse_at, output int lat, output int ndone);
        @(negedge clk);
        a = av; b = bv; b_in = binv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        lat = 0;
        ndone = 0;
        while (lat < 20) begin
            if (lat == pulse_at) begin
                start = 1'b1; a = 8'd1; b = 8'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (lat == 4) check("diff_held_in_shift", diff, prev_diff);
            if (done) begin
                ndone++;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [7:0] av, input logic [7:0] bv,
                            input logic binv, input logic [7:0] ed, input logic eb);
        int lat, nd;
        run_op(av, bv, binv, -1, lat, nd);
        check({tag, "_latency"}, lat, 8);
        check({tag, "_diff"}, diff, ed);
        check({tag, "_borrow"}, borrow, eb);
        prev_diff = ed;
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_busy_clear"}, busy, 0);
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic ovf_case(input string tag, input logic [7:0] av, input logic [7:0] bv,
                            input logic [7:0] ed, input logic eo);
        int lat, nd;
        run_op(av, bv, 1'b0, -1, lat, nd);
        check({tag, "_diff"}, diff, ed);
        check({tag, "_ovf"}, ovf, eo);
        prev_diff = ed;
        @(posedge clk); #1;
    endtask
`endif

    // Cell truth table, rows indexed {a,b,bin}: {d,bout}.
    logic [1:0] cell_tbl [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

    initial begin
        int lat, nd, extra;
        logic [7:0] ra, rb;
        logic       rbin;
        logic [8:0] ref_full;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
        ca = 0; cb = 0; cbin = 0;
        prev_diff = 8'd0;

        // Exhaustive cell check.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] idx;
            idx = 3'(i);
            {ca, cb, cbin} = idx;
            #1;
            check($sformatf("cell_%0d", i), {cd, cbout}, cell_tbl[i]);
        end

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_diff", diff, 0);
        check("reset_borrow", borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("reset_ovf", ovf, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        directed("t1", 8'd100, 8'd58, 1'b0, 8'd42, 1'b0);
        directed("t2", 8'd5, 8'd9, 1'b0, 8'hFC, 1'b1);
        directed("t3", 8'd0, 8'd0, 1'b1, 8'hFF, 1'b1);

        // Start re-pulsed during the 3rd SHIFT cycle must be ignored.
        run_op(8'd20, 8'd7, 1'b0, 2, lat, nd);
        check("t4_latency", lat, 8);
        check("t4_diff", diff, 8'd13);
        check("t4_borrow", borrow, 0);
        prev_diff = 8'd13;
        extra = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check("t4_extra_done", extra, 0);

        // Reset asserted during the 4th SHIFT cycle aborts the operation.
        @(negedge clk);
        a = 8'd50; b = 8'd1; b_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_diff", diff, 0);
        check("t5_rst_borrow", borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("t5_rst_ovf", ovf, 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check("t5_no_done", extra, 0);
        prev_diff = 8'd0;
        directed("t5", 8'd200, 8'd55, 1'b0, 8'd145, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
        ovf_case("ovf_a", 8'h80, 8'h01, 8'h7F, 1'b1);
        ovf_case("ovf_b", 8'h7F, 8'hFF, 8'h80, 1'b1);
        ovf_case("ovf_c", 8'd10, 8'd3, 8'd7, 1'b0);
`endif

        // Random operations against a 9-bit arithmetic reference.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rbin = 1'($urandom);
            ref_full = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
            run_op(ra, rb, rbin, -1, lat, nd);
            check("rnd_latency", lat, 8);
            check("rnd_diff", diff, ref_full[7:0]);
            check("rnd_borrow", borrow, ref_full[8]);
`ifdef SERIAL_SUB_OVF_EN
            check("rnd_ovf", ovf, (ra[7] != rb[7]) && (ref_full[7] != ra[7]));
`endif
            prev_diff = ref_full[7:0];
            @(posedge clk); #1;
            check("rnd_busy_clear", busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
